// File: rtl/jtag_sci_pkg.sv
// Shared types and field offsets for the JTAG-to-SCI burst bridge.
// Command and status positions are relative to the frame and response layout.
package jtag_sci_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } fsm_t;

  // command bits sit just above the address field
  localparam int CMD_VALID = 0;
  localparam int CMD_RD    = 1;
  localparam int CMD_INC   = 2;

  // status bits sit just above last_rdata in the response
  localparam int ST_RDV = 0;
  localparam int ST_TMO = 1;
  localparam int ST_OVR = 2;

endpackage

// File: rtl/jtag_sci_deser.sv
// Frame deserialiser: shift register, bit counter and response load.
// The completed frame is presented combinationally on the done cycle.
module jtag_sci_deser #(
  parameter int FRAME_W = 29,
  parameter int RESP_W  = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               shift_en_i,
  input  logic               capture_i,
  input  logic               tdi_i,
  input  logic [RESP_W-1:0]  resp_i,
  output logic               frame_done_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               tdo_o
);

  localparam int CW = $clog2(FRAME_W);

  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  assign frame_o      = {tdi_i, sr_q[FRAME_W-1:1]};
  assign frame_done_o = shift_en_i && (cnt_q == CW'(FRAME_W - 1));

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (capture_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      if (frame_done_o) begin
        sr_d  = FRAME_W'(resp_i);
        cnt_d = '0;
      end else begin
        sr_d  = frame_o;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
      tdo_o <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      tdo_o <= sr_q[0];
    end
  end

endmodule

// File: rtl/jtag_sci_bridge_burst.sv
// JTAG ER2 to SCI bridge: frame decode, issue FSM, ack timeout and
// sticky report-and-clear status returned in the next frame response.
module jtag_sci_bridge_burst
  import jtag_sci_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              jtck,
  input  logic              rst,
  input  logic              jtdi,
  input  logic              jshift,
  input  logic              jce2,
  input  logic              ip_enable,
  output logic              er2_tdo,
  output logic              jcex,
  output logic [ADDR_W-1:0] sci_addr,
  output logic [DATA_W-1:0] sci_wdata,
  output logic              sci_wr,
  output logic              sci_rd,
  input  logic              sci_ack,
  input  logic [DATA_W-1:0] sci_rdata
);

  localparam int FRAME_W = ADDR_W + DATA_W + 3;
  localparam int RESP_W  = DATA_W + 3;
  localparam int VB      = ADDR_W + DATA_W;
  localparam int TW      = $clog2(ACK_TIMEOUT + 1);

  fsm_t              state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ovr_q, ovr_d;
  logic              tmo_q, tmo_d;
  logic              rdv_q, rdv_d;
  logic              jtdi_q, jshift_q, jce2_q;

  logic               frame_done;
  logic [FRAME_W-1:0] frame;
  logic [RESP_W-1:0]  resp;

  always_comb begin
    resp                  = '0;
    resp[DATA_W-1:0]      = rdata_q;
    resp[DATA_W + ST_RDV] = rdv_q;
    resp[DATA_W + ST_TMO] = tmo_q;
    resp[DATA_W + ST_OVR] = ovr_q;
  end

  jtag_sci_deser #(
    .FRAME_W (FRAME_W),
    .RESP_W  (RESP_W)
  ) u_deser (
    .clk_i        (jtck),
    .rst_i        (rst),
    .shift_en_i   (jce2_q & jshift_q),
    .capture_i    (jce2_q & ~jshift_q),
    .tdi_i        (jtdi_q),
    .resp_i       (resp),
    .frame_done_o (frame_done),
    .frame_o      (frame),
    .tdo_o        (er2_tdo)
  );

  assign jcex      = jce2_q & ip_enable;
  assign sci_addr  = addr_q;
  assign sci_wdata = wdata_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    rdv_d   = rdv_q;
    sci_rd  = 1'b0;
    sci_wr  = 1'b0;
    if (frame_done) begin
      ovr_d = 1'b0;
      tmo_d = 1'b0;
      rdv_d = 1'b0;
      if (frame[VB + CMD_VALID]) begin
        if (state_q != IDLE) begin
          ovr_d = 1'b1;
        end else begin
          addr_d  = frame[VB + CMD_INC] ? addr_q + 1'b1
                                        : frame[VB-1:DATA_W];
          wdata_d = frame[DATA_W-1:0];
          rd_d    = frame[VB + CMD_RD];
          state_d = ISSUE;
        end
      end
    end
    // completion flags are applied after the clear so they win
    unique case (state_q)
      ISSUE: begin
        sci_rd  = rd_q & ~rst;
        sci_wr  = ~rd_q & ~rst;
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sci_ack) begin
          state_d = IDLE;
          if (rd_q) begin
            rdata_d = sci_rdata;
            rdv_d   = 1'b1;
          end
        end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge jtck) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
      rdv_q    <= 1'b0;
      jtdi_q   <= 1'b0;
      jshift_q <= 1'b0;
      jce2_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
      rdv_q    <= rdv_d;
      jtdi_q   <= jtdi;
      jshift_q <= jshift;
      jce2_q   <= jce2;
    end
  end

endmodule
